// File: rtl/banked_mem_arb_if.sv
// Request/response bundle between NUM_CH requesters and the banked scratch memory.
interface banked_mem_arb_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
);
    logic [NUM_CH-1:0]               req_valid;
    logic [NUM_CH-1:0]               req_ready;
    logic [NUM_CH-1:0]               req_write;
    logic [NUM_CH-1:0]               req_dw;
    logic [NUM_CH-1:0][ADDR_W-1:0]   req_addr;
    logic [NUM_CH-1:0][2*DATA_W-1:0] req_wdata;
    logic [NUM_CH-1:0]               rsp_valid;
    logic [NUM_CH-1:0][2*DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_write, req_dw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  req_valid, req_write, req_dw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/banked_mem_arb.sv
// Bank-interleaved scratch memory, round-robin multi-grant arbiter, 2-cycle reads.
// Optional MEM_PERF_CNT_EN adds a saturating stall-cycle counter on conflict_cnt.
module banked_mem_arb_bank #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ROW_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[row] <= wdata;
            else    rdata    <= mem[row];
        end
    end
endmodule

module banked_mem_arb #(
    parameter int NUM_CH    = 4,
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 14
) (
    input  logic           clk,
    input  logic           rst,
    banked_mem_arb_if.slave bus,
    output logic           err_misaligned,
    output logic [31:0]    conflict_cnt
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int RW = ADDR_W - BW;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CW-1:0]                    rr_ptr, rr_next;
    logic                             any_grant;
    logic [NUM_CH-1:0]                grant, mis;
    logic [NUM_CH-1:0][BW-1:0]        bank_lo, bank_hi;
    logic [NUM_BANKS-1:0]             claimed, bank_en, bank_we;
    logic [NUM_BANKS-1:0][RW-1:0]     bank_row;
    logic [NUM_BANKS-1:0][DATA_W-1:0] bank_wd, bank_rd;

    logic [NUM_CH-1:0]                s1_vld, s1_dw, s1_mis, rsp_vld_q;
    logic [NUM_CH-1:0][BW-1:0]        s1_bank;
    logic [NUM_CH-1:0][2*DATA_W-1:0]  rd_asm, rsp_data_q;

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bank_lo[ch] = bus.req_addr[ch][BW-1:0];
            bank_hi[ch] = bank_lo[ch] + BW'(1);
            mis[ch]     = bus.req_dw[ch] & bus.req_addr[ch][0];
        end
    end

    // Scan from rr_ptr; a request wins only if all banks it touches are still free.
    always_comb begin
        grant     = '0;
        claimed   = '0;
        any_grant = 1'b0;
        rr_next   = rr_ptr;
        bank_en   = '0;
        bank_we   = '0;
        bank_row  = '0;
        bank_wd   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            int c;
            c = (int'(rr_ptr) + i) % NUM_CH;
            if (!rst && bus.req_valid[c] && !claimed[bank_lo[c]] &&
                !(bus.req_dw[c] && claimed[bank_hi[c]])) begin
                grant[c] = 1'b1;
                claimed[bank_lo[c]] = 1'b1;
                if (bus.req_dw[c]) claimed[bank_hi[c]] = 1'b1;
                if (!any_grant) rr_next = (c == NUM_CH - 1) ? '0 : CW'(c + 1);
                any_grant = 1'b1;
                if (!mis[c]) begin
                    bank_en[bank_lo[c]]  = 1'b1;
                    bank_we[bank_lo[c]]  = bus.req_write[c];
                    bank_row[bank_lo[c]] = bus.req_addr[c][ADDR_W-1:BW];
                    bank_wd[bank_lo[c]]  = bus.req_wdata[c][DATA_W-1:0];
                    if (bus.req_dw[c]) begin
                        bank_en[bank_hi[c]]  = 1'b1;
                        bank_we[bank_hi[c]]  = bus.req_write[c];
                        bank_row[bank_hi[c]] = bus.req_addr[c][ADDR_W-1:BW];
                        bank_wd[bank_hi[c]]  = bus.req_wdata[c][2*DATA_W-1:DATA_W];
                    end
                end
            end
        end
    end

    assign bus.req_ready = grant;

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        banked_mem_arb_bank #(.DATA_W(DATA_W), .ROW_W(RW)) u_bank (
            .clk   (clk),
            .en    (bank_en[k]),
            .we    (bank_we[k]),
            .row   (bank_row[k]),
            .wdata (bank_wd[k]),
            .rdata (bank_rd[k])
        );
    end

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rd_asm[ch] = '0;
            if (!s1_mis[ch]) begin
                rd_asm[ch][DATA_W-1:0] = bank_rd[s1_bank[ch]];
                if (s1_dw[ch]) rd_asm[ch][2*DATA_W-1:DATA_W] = bank_rd[s1_bank[ch] + BW'(1)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr         <= '0;
            s1_vld         <= '0;
            s1_dw          <= '0;
            s1_mis         <= '0;
            s1_bank        <= '0;
            rsp_vld_q      <= '0;
            rsp_data_q     <= '0;
            err_misaligned <= 1'b0;
        end else begin
            rr_ptr    <= rr_next;
            s1_vld    <= grant & ~bus.req_write;
            s1_dw     <= bus.req_dw;
            s1_mis    <= mis;
            s1_bank   <= bank_lo;
            rsp_vld_q <= s1_vld;
            for (int ch = 0; ch < NUM_CH; ch++)
                if (s1_vld[ch]) rsp_data_q[ch] <= rd_asm[ch];
            if (|(grant & mis)) err_misaligned <= 1'b1;
        end
    end

    // Masking with rst drops the response of a read granted two cycles before reset.
    assign bus.rsp_valid = rsp_vld_q & {NUM_CH{~rst}};
    assign bus.rsp_data  = rsp_data_q;

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (|(bus.req_valid & ~grant) && conflict_cnt != 32'hFFFF_FFFF)
            conflict_cnt <= conflict_cnt + 32'd1;
    end
`else
    assign conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_banked_mem_arb.sv
// Vector table, reset sequence and random traffic checked against a queue/array reference model.
module tb_banked_mem_arb;
    localparam int NCH = 4, NB = 4, DW = 16, AW = 14;
`ifdef MEM_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
    logic [31:0] cnt;
    always #5 clk = ~clk;

    banked_mem_arb_if #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW)) bus ();
    banked_mem_arb #(.NUM_CH(NCH), .NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .err_misaligned(err), .conflict_cnt(cnt));

    typedef struct {
        logic [3:0] v, w, dw;
        logic [3:0][13:0] a;
        logic [3:0][31:0] wd;
    } stim_t;
    typedef struct {
        stim_t s;
        logic [3:0] exp_rdy, exp_rv;
        int rd_ch;
        logic [31:0] rd_val;
        logic exp_err;
        bit chk_cnt;
    } vec_t;

    int n_chk = 0, n_fail = 0;

    // reference model state
    logic [15:0] mem [int];
    int m_rr;
    logic [3:0] m_s1_vld, m_s1_known, m_rv, m_known;
    logic [3:0][31:0] m_s1_data, m_rd;
    logic m_err;
    logic [31:0] m_cnt;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_s1_vld = '0; m_s1_known = '1; m_s1_data = '0;
        m_rv = '0; m_known = '1; m_rd = '0; m_err = 1'b0; m_cnt = '0;
    endtask

    task automatic check_out();
        chk("rsp_valid", bus.rsp_valid, m_rv);
        for (int ch = 0; ch < NCH; ch++)
            if (m_known[ch]) chk($sformatf("rsp_data[%0d]", ch), bus.rsp_data[ch], m_rd[ch]);
        chk("err_misaligned", err, m_err);
        chk("conflict_cnt", cnt, CNT_ON ? m_cnt : 32'd0);
    endtask

    task automatic drive(stim_t s, logic r);
        rst = r;
        bus.req_valid = s.v; bus.req_write = s.w; bus.req_dw = s.dw;
        bus.req_addr = s.a; bus.req_wdata = s.wd;
    endtask

    // Grants from the scan rule, then advances the model one clock edge.
    task automatic eval(stim_t s, logic r);
        logic [3:0] g;
        bit used [NB];
        int first;
        g = '0; first = -1;
        for (int b = 0; b < NB; b++) used[b] = 1'b0;
        if (!r) begin
            for (int k = 0; k < NCH; k++) begin
                int c, b0, b1;
                c = (m_rr + k) % NCH;
                b0 = int'(s.a[c]) % NB;
                b1 = (b0 + 1) % NB;
                if (s.v[c] && !used[b0] && !(s.dw[c] && used[b1])) begin
                    g[c] = 1'b1; used[b0] = 1'b1;
                    if (s.dw[c]) used[b1] = 1'b1;
                    if (first < 0) first = c;
                end
            end
        end
        chk("req_ready", bus.req_ready, g);
        if (r) begin
            chk("rsp_valid_in_rst", bus.rsp_valid, 4'b0);
            model_reset();
        end else begin
            if ((s.v & ~g) != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt++;
            m_rv = m_s1_vld;
            for (int ch = 0; ch < NCH; ch++)
                if (m_s1_vld[ch]) begin m_rd[ch] = m_s1_data[ch]; m_known[ch] = m_s1_known[ch]; end
            for (int ch = 0; ch < NCH; ch++) begin
                int a;
                logic mis;
                a = int'(s.a[ch]);
                mis = s.dw[ch] & s.a[ch][0];
                m_s1_vld[ch] = g[ch] & ~s.w[ch];
                m_s1_data[ch] = '0; m_s1_known[ch] = 1'b1;
                if (g[ch] && mis) m_err = 1'b1;
                if (m_s1_vld[ch] && !mis) begin
                    m_s1_known[ch] = mem.exists(a) && (!s.dw[ch] || mem.exists(a + 1));
                    if (mem.exists(a)) m_s1_data[ch][15:0] = mem[a];
                    if (s.dw[ch] && mem.exists(a + 1)) m_s1_data[ch][31:16] = mem[a + 1];
                end
            end
            for (int ch = 0; ch < NCH; ch++)
                if (g[ch] && s.w[ch] && !(s.dw[ch] && s.a[ch][0])) begin
                    mem[int'(s.a[ch])] = s.wd[ch][15:0];
                    if (s.dw[ch]) mem[int'(s.a[ch]) + 1] = s.wd[ch][31:16];
                end
            if (first >= 0) m_rr = (first + 1) % NCH;
        end
    endtask

    task automatic cycle(stim_t s, logic r);
        @(negedge clk);
        check_out();
        drive(s, r);
        #1;
        eval(s, r);
    endtask

    function automatic vec_t mk(logic [3:0] v, logic [3:0] w, logic [3:0] dw,
                                logic [13:0] a0, logic [13:0] a1, logic [13:0] a2, logic [13:0] a3,
                                logic [31:0] wd, logic [3:0] rdy, logic [3:0] rv,
                                int rd_ch, logic [31:0] rd_val, logic e, bit cc);
        vec_t t;
        t.s.v = v; t.s.w = w; t.s.dw = dw;
        t.s.a[0] = a0; t.s.a[1] = a1; t.s.a[2] = a2; t.s.a[3] = a3;
        for (int k = 0; k < NCH; k++) t.s.wd[k] = wd;
        t.exp_rdy = rdy; t.exp_rv = rv; t.rd_ch = rd_ch; t.rd_val = rd_val;
        t.exp_err = e; t.chk_cnt = cc;
        return t;
    endfunction

    function automatic stim_t one(int ch, logic w, logic dw, logic [13:0] a);
        stim_t s;
        s.v = '0; s.w = '0; s.dw = '0; s.a = '0; s.wd = '0;
        s.v[ch] = 1'b1; s.w[ch] = w; s.dw[ch] = dw; s.a[ch] = a;
        return s;
    endfunction

    initial begin
        vec_t tbl [18];
        stim_t s, idle, all4;
        logic [3:0] pend;

        idle = one(0, 1'b0, 1'b0, 14'h0); idle.v = '0;
        all4 = idle; all4.v = 4'hF;
        for (int k = 0; k < NCH; k++) all4.a[k] = 14'h4;

        drive(idle, 1'b1);
        repeat (2) @(posedge clk);
        model_reset();
        cycle(all4, 1'b1);

        //            v  w  dw a0 a1     a2 a3     wdata          rdy rv  ch rd_val        err cnt
        tbl[0]  = mk(1, 1, 0, 5, 0,     0, 0,     32'h1234,      1,  0, -1, 0,            0, 0);
        tbl[1]  = mk(1, 0, 0, 5, 0,     0, 0,     0,             1,  0, -1, 0,            0, 0);
        tbl[2]  = mk(2, 2, 2, 0, 'h10,  0, 0,     32'hBEEF_CAFE, 2,  0, -1, 0,            0, 0);
        tbl[3]  = mk(2, 0, 2, 0, 'h10,  0, 0,     0,             2,  1,  0, 32'h1234,     0, 0);
        tbl[4]  = mk(2, 0, 0, 0, 'h11,  0, 0,     0,             2,  0, -1, 0,            0, 0);
        tbl[5]  = mk(15,0, 0, 0, 1,     2, 3,     0,             15, 2,  1, 32'hBEEF_CAFE,0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0,     0, 0,     0,             0,  2,  1, 32'h0000_BEEF,0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0,     0, 0,     0,             0,  15,-1, 0,            0, 0);
        tbl[8]  = mk(8, 0, 0, 0, 0,     0, 'h11,  0,             8,  0, -1, 0,            0, 0);
        tbl[9]  = mk(15,0, 0, 4, 4,     4, 4,     0,             1,  0, -1, 0,            0, 0);
        tbl[10] = mk(14,0, 0, 4, 4,     4, 4,     0,             2,  8,  3, 32'h0000_BEEF,0, 0);
        tbl[11] = mk(12,0, 0, 4, 4,     4, 4,     0,             4,  1, -1, 0,            0, 0);
        tbl[12] = mk(8, 0, 0, 4, 4,     4, 4,     0,             8,  2, -1, 0,            0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0,     0, 0,     0,             0,  4, -1, 0,            0, 1);
        tbl[14] = mk(4, 0, 4, 0, 0,     3, 0,     0,             4,  8, -1, 0,            0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0,     0, 0,     0,             0,  0, -1, 0,            1, 0);
        tbl[16] = mk(0, 0, 0, 0, 0,     0, 0,     0,             0,  4,  2, 32'h0,        1, 0);
        tbl[17] = mk(0, 0, 0, 0, 0,     0, 0,     0,             0,  0, -1, 0,            1, 0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check_out();
            chk($sformatf("tbl%0d rsp_valid", i), bus.rsp_valid, tbl[i].exp_rv);
            if (tbl[i].rd_ch >= 0)
                chk($sformatf("tbl%0d rsp_data", i), bus.rsp_data[tbl[i].rd_ch], tbl[i].rd_val);
            chk($sformatf("tbl%0d err", i), err, tbl[i].exp_err);
            if (tbl[i].chk_cnt) chk($sformatf("tbl%0d conflict_cnt", i), cnt, CNT_ON ? 32'd3 : 32'd0);
            drive(tbl[i].s, 1'b0);
            #1;
            chk($sformatf("tbl%0d req_ready", i), bus.req_ready, tbl[i].exp_rdy);
            eval(tbl[i].s, 1'b0);
        end

        // reads in flight across reset are dropped; rr_ptr and err return to reset values
        cycle(one(1, 1'b0, 1'b0, 14'h11), 1'b0);
        cycle(one(0, 1'b0, 1'b0, 14'h5), 1'b0);
        @(negedge clk);
        check_out();
        drive(all4, 1'b1);
        #1;
        chk("ready_in_rst", bus.req_ready, 4'b0);
        chk("rsp_masked_in_rst", bus.rsp_valid, 4'b0);
        eval(all4, 1'b1);
        @(negedge clk);
        check_out();
        chk("rsp_valid_after_rst", bus.rsp_valid, 4'b0);
        chk("rsp_data0_after_rst", bus.rsp_data[0], 32'h0);
        chk("err_after_rst", err, 1'b0);
        chk("cnt_after_rst", cnt, 32'h0);
        s = all4; s.v = 4'b0001;
        drive(all4, 1'b0);
        #1;
        chk("rr_after_rst", bus.req_ready, 4'b0001);
        eval(all4, 1'b0);
        cycle(one(0, 1'b0, 1'b0, 14'h5), 1'b0);
        cycle(idle, 1'b0);
        cycle(idle, 1'b0);
        @(negedge clk);
        chk("write_persists", bus.rsp_data[0], 32'h0000_1234);
        check_out();
        drive(idle, 1'b0);
        #1;
        eval(idle, 1'b0);

        // preload 0..31, then random contended traffic
        for (int k = 0; k < 8; k++) begin
            s = idle; s.v = 4'hF; s.w = 4'hF;
            for (int ch = 0; ch < NCH; ch++) begin
                s.a[ch] = 14'(4 * k + ch);
                s.wd[ch] = $urandom;
            end
            cycle(s, 1'b0);
        end
        s = idle; pend = '0;
        for (int it = 0; it < 600; it++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (pend[ch] && $urandom_range(7) == 0) pend[ch] = 1'b0;
                if (!pend[ch] && $urandom_range(1) == 1) begin
                    s.w[ch]  = 1'($urandom_range(1));
                    s.dw[ch] = ($urandom_range(2) == 0);
                    s.a[ch]  = 14'($urandom_range(31));
                    if (s.dw[ch] && $urandom_range(9) != 0) s.a[ch][0] = 1'b0;
                    s.wd[ch] = $urandom;
                    pend[ch] = 1'b1;
                end
            end
            s.v = pend;
            cycle(s, (it == 300));
            pend = pend & ~bus.req_ready;
        end
        repeat (3) cycle(idle, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
